// File: rtl/input_conditioner.sv
// input_conditioner: synchronises, debounces and edge-detects WIDTH asynchronous inputs.
module input_conditioner #(
    parameter int WIDTH = 4,
    parameter int SYNC_STAGES = 2,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic             changed
);
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    logic [WIDTH-1:0] sync [SYNC_STAGES];
    logic [WIDTH-1:0] s, diff, hit;
    logic [CNT_W-1:0] cnt [WIDTH];
    assign s = sync[SYNC_STAGES-1];
    assign diff = s ^ dout;
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            for (int k = 0; k < SYNC_STAGES; k++) sync[k] <= '0;
        end else begin
            sync[0] <= din;
            for (int k = 1; k < SYNC_STAGES; k++) sync[k] <= sync[k-1];
        end
    // a channel flips once its disagreement has lasted DEBOUNCE_CYCLES edges
    always_comb begin
        hit = '0;
        for (int i = 0; i < WIDTH; i++) hit[i] = diff[i] && (cnt[i] == LAST);
    end
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            dout <= '0;
            rise <= '0;
            fall <= '0;
            changed <= 1'b0;
            for (int i = 0; i < WIDTH; i++) cnt[i] <= '0;
        end else begin
            dout <= dout ^ hit;
            rise <= hit & s;
            fall <= hit & ~s;
            changed <= |hit;
            for (int i = 0; i < WIDTH; i++) cnt[i] <= (diff[i] && !hit[i]) ? cnt[i] + CNT_W'(1) : '0;
        end
endmodule
